wave_addr_gen: RTL and testbench

//  Phase-accumulator address generator, the initiator side of the wavetable read interface.
//  - Once per sample period it advances a phase accumulator.
//  - It drives the wavetable lookup address, then captures the returned sample.
//  - It presents that sample to the downstream DAC/serializer over a valid/ready handshake.
//  - Sits between the wavetable ROMs (e.g. square_wave) and the audio output path, clocked at 5 MHz.

---
 rtl/wave_addr_gen.sv | 125 ++++++++++++
 tb/tb_wave_addr_gen.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/wave_addr_gen.sv
// Phase-accumulator wavetable address generator: advances the phase once per sample period,
// reads the wavetable and hands each sample downstream over a valid/ready handshake.
module wave_addr_gen #(
   parameter int unsigned ADDR_W  = 16,
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned PHASE_W = 24,
   parameter int unsigned DIV     = 113,
   parameter int unsigned LUT_LAT = 1
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_enable,
   input  logic               i_sync,
   input  logic [PHASE_W-1:0] i_tune,
   output logic [ADDR_W-1:0]  o_addr,
   input  logic [DATA_W-1:0]  i_data,
   output logic [DATA_W-1:0]  o_sample,
   output logic               o_valid,
   input  logic               i_ready,
   output logic               o_overrun
);

   localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned LAT_W = $clog2(LUT_LAT + 2);

   typedef enum logic [1:0] {StIdle, StLookup, StHold} state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [PHASE_W-1:0] phase_q, phase_d, phase_sum;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [LAT_W-1:0]   lat_q, lat_d;
   logic [DATA_W-1:0]  sample_q, sample_d;
   logic               valid_q, valid_d;
   logic               overrun_q, overrun_d;
   logic               tick, start, accept;

   always_comb begin
      tick      = (cnt_q == CNT_W'(DIV - 1)) && i_enable;
      // A sync in the tick cycle suppresses both the increment and the lookup.
      start     = tick && !i_sync;
      accept    = valid_q && i_ready;
      phase_sum = phase_q + i_tune;

      cnt_d     = cnt_q;
      phase_d   = phase_q;
      addr_d    = addr_q;
      lat_d     = lat_q;
      state_d   = state_q;
      sample_d  = sample_q;
      valid_d   = valid_q;
      overrun_d = 1'b0;

      if (i_sync) begin
         cnt_d   = '0;
         phase_d = '0;
         addr_d  = '0;
      end else if (i_enable) begin
         cnt_d = tick ? '0 : cnt_q + 1'b1;
         if (tick) begin
            phase_d = phase_sum;
            addr_d  = phase_sum[PHASE_W-1 -: ADDR_W];
         end
      end

      if (accept) valid_d = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StLookup;
               lat_d   = '0;
            end
         end
         StLookup: begin
            if (lat_q == LAT_W'(LUT_LAT)) begin
               sample_d  = i_data;
               valid_d   = 1'b1;
               // Accept on the capture edge takes the old sample, so it is not an overrun.
               overrun_d = valid_q && !i_ready;
               state_d   = StHold;
            end else begin
               lat_d = lat_q + 1'b1;
            end
         end
         StHold: begin
            if (start) begin
               state_d = StLookup;
               lat_d   = '0;
            end else if (accept) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         phase_q   <= '0;
         addr_q    <= '0;
         lat_q     <= '0;
         sample_q  <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         phase_q   <= phase_d;
         addr_q    <= addr_d;
         lat_q     <= lat_d;
         sample_q  <= sample_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
      end
   end

   assign o_addr    = addr_q;
   assign o_sample  = sample_q;
   assign o_valid   = valid_q;
   assign o_overrun = overrun_q;

endmodule

// File: tb/tb_wave_addr_gen.sv
// Directed bench for wave_addr_gen: ramp, wrap, backpressure, sync collision, enable and reset.
module tb_wave_addr_gen;

   localparam int unsigned DIV = 113;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic        sync;
   logic [23:0] tune;
   logic [15:0] addr;
   logic [15:0] rom_data = 16'h0000;
   logic [15:0] sample;
   logic        valid;
   logic        ready;
   logic        overrun;

   int tests = 0;
   int fails = 0;
   int mcnt  = 0;

   wave_addr_gen dut (
      .i_clk     (clk),
      .i_rst_n   (rst_n),
      .i_enable  (enable),
      .i_sync    (sync),
      .i_tune    (tune),
      .o_addr    (addr),
      .i_data    (rom_data),
      .o_sample  (sample),
      .o_valid   (valid),
      .i_ready   (ready),
      .o_overrun (overrun)
   );

   always #100 clk = ~clk;

   function automatic logic [15:0] rom_f(input logic [15:0] a);
      return {a[7:0], a[15:8]} ^ 16'h5A5A;
   endfunction

   // One-cycle-latency wavetable.
   always @(posedge clk) rom_data <= rom_f(addr);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance n edges, tracking the expected tick counter; leaves time at edge+1.
   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         if (!rst_n || sync) mcnt = 0;
         else if (enable) mcnt = (mcnt == DIV - 1) ? 0 : mcnt + 1;
         #1;
      end
   endtask

   task automatic to_tick_cycle();
      for (int i = 0; i < 2 * DIV && mcnt != DIV - 1; i++) step(1);
   endtask

   // Advance to just after the edge ending the next tick cycle.
   task automatic to_e();
      to_tick_cycle();
      step(1);
   endtask

   initial begin
      rst_n  = 1'b0;
      enable = 1'b1;
      sync   = 1'b0;
      tune   = 24'h000100;
      ready  = 1'b1;
      step(3);
      chk("rst_addr", addr, 16'h0000);
      chk("rst_valid", valid, 1'b0);
      chk("rst_overrun", overrun, 1'b0);
      chk("rst_sample", sample, 16'h0000);
      rst_n = 1'b1;

      // Ramp
      step(112);
      chk("no_early_tick", addr, 16'h0000);
      step(1);
      chk("ramp_addr1", addr, 16'h0001);
      step(1);
      chk("ramp_valid_lat", valid, 1'b0);
      step(1);
      chk("ramp_valid1", valid, 1'b1);
      chk("ramp_sample1", sample, rom_f(16'h0001));
      step(1);
      chk("ramp_accept1", valid, 1'b0);
      to_e();
      chk("ramp_addr2", addr, 16'h0002);
      step(2);
      chk("ramp_sample2", sample, rom_f(16'h0002));
      to_e();
      chk("ramp_addr3", addr, 16'h0003);
      step(2);
      chk("ramp_sample3", sample, rom_f(16'h0003));

      // Wrap: preset phase to FFFF00, then step by 0x200
      tune = 24'hFFFC00;
      to_e();
      chk("preset_addr", addr, 16'hFFFF);
      step(2);
      chk("preset_sample", sample, rom_f(16'hFFFF));
      tune = 24'h000200;
      to_e();
      chk("wrap_addr", addr, 16'h0001);
      step(2);
      chk("wrap_valid", valid, 1'b1);
      chk("wrap_sample", sample, rom_f(16'h0001));
      chk("wrap_overrun", overrun, 1'b0);
      step(1);
      chk("wrap_accept", valid, 1'b0);

      // Backpressure
      ready = 1'b0;
      to_e();
      chk("bp_addr3", addr, 16'h0003);
      step(2);
      chk("bp_valid3", valid, 1'b1);
      chk("bp_no_overrun", overrun, 1'b0);
      to_e();
      chk("bp_addr5", addr, 16'h0005);
      chk("bp_hold3", sample, rom_f(16'h0003));
      step(2);
      chk("bp_overrun5", overrun, 1'b1);
      chk("bp_sample5", sample, rom_f(16'h0005));
      chk("bp_valid5", valid, 1'b1);
      step(1);
      chk("bp_overrun_pulse", overrun, 1'b0);
      to_e();
      chk("bp_addr7", addr, 16'h0007);
      chk("bp_hold5", sample, rom_f(16'h0005));
      step(2);
      chk("bp_overrun7", overrun, 1'b1);
      chk("bp_sample7", sample, rom_f(16'h0007));
      step(1);
      chk("bp_still_valid", valid, 1'b1);
      ready = 1'b1;
      step(1);
      chk("bp_accept", valid, 1'b0);
      chk("bp_hold7", sample, rom_f(16'h0007));

      // Accept on the capture edge
      ready = 1'b0;
      to_e();
      chk("ac_addr9", addr, 16'h0009);
      step(2);
      chk("ac_sample9", sample, rom_f(16'h0009));
      to_e();
      chk("ac_addrB", addr, 16'h000B);
      step(1);
      ready = 1'b1;
      step(1);
      chk("ac_valid", valid, 1'b1);
      chk("ac_sampleB", sample, rom_f(16'h000B));
      chk("ac_no_overrun", overrun, 1'b0);
      step(1);
      chk("ac_drained", valid, 1'b0);

      // Sync collision with phase 123400
      tune = 24'h122900;
      to_e();
      chk("sy_addr1234", addr, 16'h1234);
      tune = 24'h004500;
      step(3);
      to_tick_cycle();
      sync = 1'b1;
      step(1);
      sync = 1'b0;
      chk("sy_addr0", addr, 16'h0000);
      step(2);
      chk("sy_no_lookup", valid, 1'b0);
      step(110);
      chk("sy_cnt_cleared", addr, 16'h0000);
      step(1);
      chk("sy_addr45", addr, 16'h0045);
      step(2);
      chk("sy_sample45", sample, rom_f(16'h0045));

      // Enable drop right after a tick
      to_e();
      chk("en_addr8A", addr, 16'h008A);
      enable = 1'b0;
      step(2);
      chk("en_valid", valid, 1'b1);
      chk("en_sample8A", sample, rom_f(16'h008A));
      step(200);
      chk("en_frozen", addr, 16'h008A);
      chk("en_no_lookup", valid, 1'b0);
      enable = 1'b1;
      to_e();
      chk("en_addrCF", addr, 16'h00CF);

      // Reset during the lookup
      step(1);
      rst_n = 1'b0;
      #1;
      chk("mr_valid_async", valid, 1'b0);
      step(3);
      chk("mr_addr", addr, 16'h0000);
      chk("mr_sample", sample, 16'h0000);
      rst_n = 1'b1;
      step(3);
      chk("mr_no_valid", valid, 1'b0);
      chk("mr_no_overrun", overrun, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
